gru_hidden_update: RTL
======================

Name: gru_hidden_update

Overview:
- Final stage of the GRU cell: computes h_t[i] = (1-z[i])*h_{t-1}[i] + z[i]*h_cand[i], one element per accepted beat.
- Sits directly downstream of the (1-z) subtractor, which supplies one_minus_z_in; z_in and h_cand_in come from the update-gate and candidate (tanh) stages.
- Holds the h_{t-1} register bank internally and overwrites each entry with its new value.
- Streams h_t out with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, width of every data word; Q4.4 fixed point.
- FRAC_BITS, 4, fractional bits; ONE = 1<<FRAC_BITS = 8'b00010000.
- HIDDEN_SIZE, 16, number of hidden elements per time step. Must be >= 3, checked by an elaboration assertion.
- IDX_WIDTH, $clog2(HIDDEN_SIZE), element index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- clear_state  input  1  zero h_{t-1} bank and flush the pipeline (start of a new sequence)
- in_valid  input  1  z_in, one_minus_z_in and h_cand_in are valid
- in_ready  output  1  block accepts the beat this cycle
- z_in  input  DATA_WIDTH  update gate, unsigned Q4.4
- one_minus_z_in  input  DATA_WIDTH  (1-z), unsigned Q4.4
- h_cand_in  input  DATA_WIDTH  candidate state, signed Q4.4
- out_valid  output  1  h_out is valid
- out_ready  input  1  consumer accepts h_out
- h_out  output  DATA_WIDTH  new hidden element, signed Q4.4
- h_idx_out  output  IDX_WIDTH  element index of h_out
- step_done  output  1  high with out_valid on the last element (index HIDDEN_SIZE-1)

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, h_out=0, h_idx_out=0, step_done=0.
  - Both stage valids = 0, element counter = 0, all HIDDEN_SIZE bank entries = 0.
  - in_ready=1 in the first cycle after reset.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~clear_state.
  - A beat is accepted when in_valid & in_ready.
  - While stalled, every pipeline register holds its value and h_out stays stable.
- Pipeline, 2 stages; a beat accepted at edge k gives out_valid from edge k+2.
  - S1 (on accept) registers:
    - pA = signed({1'b0,one_minus_z_in}) * signed(bank[cnt]), 17-bit signed.
    - pB = signed({1'b0,z_in}) * signed(h_cand_in), 17-bit signed.
    - idx = cnt, s1_valid = 1.
    - cnt increments, wrapping HIDDEN_SIZE-1 -> 0.
  - S2 (when not stalled):
    - sum = pA + pB, 18-bit.
    - r = sum >>> FRAC_BITS, arithmetic (floor toward -inf, no rounding).
    - Saturate r to [-128, 127] and load h_out, h_idx_out, out_valid = s1_valid, step_done = s1_valid & (idx == HIDDEN_SIZE-1).
    - bank[idx] is written with the saturated value on the same edge, but only if s1_valid.
  - A slot with no new beat advances with valid = 0 (bubble).
- Hazard: bank[i] is re-read no earlier than HIDDEN_SIZE beats after its previous read. HIDDEN_SIZE >= 3 guarantees the write-back has landed, so no forwarding logic is needed.
- Gate inputs are not checked: one_minus_z_in + z_in != ONE is computed as given.
- clear_state (synchronous, any time including mid-step):
  - Next edge: all bank entries = 0, cnt = 0, both stage valids = 0, out_valid = 0, step_done = 0.
  - In-flight beats are discarded and no beat is accepted that cycle.
  - Priority: rst > clear_state > normal operation.
- Simultaneous accept and output handshake in one cycle is normal full throughput: one element per cycle while out_ready=1.

Decomposition:
- Package gru_fixed_pkg holds:
  - DATA_WIDTH, FRAC_BITS and ONE.
  - Typedefs q44_t (signed DATA_WIDTH) and prod_t (17-bit signed).
  - Function sat_q44(18-bit) -> q44_t.
- Sub-module gru_mac_sat: combinational pA+pB, shift and saturate, reusable by the other GRU gate stages.
- The top module contains the counter, the bank, the stage registers and the handshake.

Test Plan:
- rst, then z=0x08, 1-z=0x08, h_cand=0x20 on idx 0 (bank 0):
  - h_out=0x10, out_valid at accept+2, h_idx_out=0.
  - Next step, same inputs: bank 0x10 -> h_out=0x18.
- Saturation:
  - z=0x20, 1-z=0x00, h_cand=0x7F -> 0x7F (254 clipped).
  - h_cand=0x80 -> 0x80 (-256 clipped).
  - z=0x10, h_cand=0x80 -> 0x80 exact.
- Truncation: z=0x01, 1-z=0x0F, bank 0:
  - h_cand=0x01 -> 0x00.
  - h_cand=0xFF -> 0xFF (floor).
- Back-to-back stream of HIDDEN_SIZE beats with out_ready=1:
  - one output per cycle, indices 0..15.
  - step_done only with idx 15.
  - cnt wraps to 0 for the next step.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream:
  - in_ready=0 while out_valid.
  - h_out and h_idx_out stable.
  - No beat lost or duplicated after release.
- Assert clear_state with 2 beats in flight:
  - out_valid=0 next cycle, in_ready=0 during clear.
  - Next beat idx=0 with bank 0: z=0x10, h_cand=0x30 -> 0x30.
  - rst mid-stream behaves the same and also zeroes h_out.

Source files
------------

// File: rtl/gru_fixed_pkg.sv
// Q4.4 fixed-point types and helpers shared by the GRU datapath stages.
// Products are 17-bit signed, sums 18-bit signed, results saturate back to Q4.4.
package gru_fixed_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int FRAC_BITS  = 4;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH + 1;
   localparam int SUM_WIDTH  = PROD_WIDTH + 1;

   typedef logic signed [DATA_WIDTH-1:0] q44_t;
   typedef logic signed [PROD_WIDTH-1:0] prod_t;
   typedef logic signed [SUM_WIDTH-1:0]  sum_t;

   localparam sum_t Q44_MAX = sum_t'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam sum_t Q44_MIN = -sum_t'(2 ** (DATA_WIDTH - 1));

   // Unsigned gate value times signed state; both widened to 17 bits before the multiply.
   function automatic prod_t mul_us(input logic [DATA_WIDTH-1:0] u, input q44_t s);
      prod_t a;
      prod_t b;
      a = prod_t'({{(PROD_WIDTH - DATA_WIDTH){1'b0}}, u});
      b = prod_t'({{(PROD_WIDTH - DATA_WIDTH){s[DATA_WIDTH-1]}}, s});
      return a * b;
   endfunction

   // Arithmetic shift floors toward -inf; no rounding, then clip to the Q4.4 range.
   function automatic q44_t sat_q44(input sum_t sum);
      sum_t r;
      r = sum >>> FRAC_BITS;
      if (r > Q44_MAX) begin
         return q44_t'(Q44_MAX[DATA_WIDTH-1:0]);
      end
      if (r < Q44_MIN) begin
         return q44_t'(Q44_MIN[DATA_WIDTH-1:0]);
      end
      return q44_t'(r[DATA_WIDTH-1:0]);
   endfunction

endpackage

// File: rtl/gru_mac_sat.sv
// Combinational pA + pB, rescale by FRAC_BITS and saturate to Q4.4.
// Shared by every GRU stage that blends two products into one state word.
module gru_mac_sat
   import gru_fixed_pkg::*;
(
   input  logic [PROD_WIDTH-1:0] pa_i,
   input  logic [PROD_WIDTH-1:0] pb_i,
   output logic [DATA_WIDTH-1:0] h_o
);

   sum_t sum;

   assign sum = sum_t'({pa_i[PROD_WIDTH-1], pa_i}) + sum_t'({pb_i[PROD_WIDTH-1], pb_i});
   assign h_o = sat_q44(sum);

endmodule

// File: rtl/gru_hidden_update.sv
// GRU output stage: h_t[i] = (1-z)*h_{t-1}[i] + z*h_cand[i], one element per beat.
// Two-stage pipeline (multiply, then add/saturate/write-back) with an internal h_{t-1} bank.
module gru_hidden_update
   import gru_fixed_pkg::*;
#(
   parameter int HIDDEN_SIZE = 16,
   parameter int IDX_WIDTH   = $clog2(HIDDEN_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_state,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] z_in,
   input  logic [DATA_WIDTH-1:0] one_minus_z_in,
   input  logic [DATA_WIDTH-1:0] h_cand_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] h_out,
   output logic [IDX_WIDTH-1:0]  h_idx_out,
   output logic                  step_done
);

   // Write-back lands one edge after the read, so a bank of at least 3 needs no forwarding.
   if (HIDDEN_SIZE < 3 || ONE != DATA_WIDTH'(1 << FRAC_BITS)) begin : g_param_check
      $error("gru_hidden_update: HIDDEN_SIZE must be >= 3 and ONE must equal 1<<FRAC_BITS");
   end

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HIDDEN_SIZE - 1);

   typedef struct packed {
      logic                 valid;
      logic [IDX_WIDTH-1:0] idx;
      prod_t                pa;
      prod_t                pb;
   } s1_t;

   s1_t                  s1_q, s1_d;
   logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   q44_t                 h_out_q, h_out_d;
   logic [IDX_WIDTH-1:0] h_idx_q, h_idx_d;
   logic                 step_done_q, step_done_d;
   q44_t                 bank_q [HIDDEN_SIZE];

   logic                 stall;
   logic                 accept;
   logic                 bank_we;
   logic [DATA_WIDTH-1:0] h_new;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall & ~clear_state;
   assign accept   = in_valid & in_ready;

   gru_mac_sat u_mac (
      .pa_i (s1_q.pa),
      .pb_i (s1_q.pb),
      .h_o  (h_new)
   );

   always_comb begin
      // NOTE: every _d starts from its hold value so no path through this block infers a latch.
      s1_d        = s1_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      h_out_d     = h_out_q;
      h_idx_d     = h_idx_q;
      step_done_d = step_done_q;
      bank_we     = 1'b0;

      if (clear_state) begin
         s1_d.valid  = 1'b0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         step_done_d = 1'b0;
      end else if (!stall) begin
         s1_d.valid = accept;
         if (accept) begin
            s1_d.idx = cnt_q;
            s1_d.pa  = mul_us(one_minus_z_in, bank_q[cnt_q]);
            s1_d.pb  = mul_us(z_in, q44_t'(h_cand_in));
            cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_WIDTH'(1);
         end
         // Bubbles advance too: an empty S1 slot clears out_valid.
         out_valid_d = s1_q.valid;
         h_out_d     = q44_t'(h_new);
         h_idx_d     = s1_q.idx;
         step_done_d = s1_q.valid && (s1_q.idx == LAST_IDX);
         bank_we     = s1_q.valid;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbours.
      if (rst) begin
         s1_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         h_out_q     <= '0;
         h_idx_q     <= '0;
         step_done_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         h_out_q     <= h_out_d;
         h_idx_q     <= h_idx_d;
         step_done_q <= step_done_d;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the bank is a flop array rather than a RAM because it must zero in one edge.
      if (rst || clear_state) begin
         for (int i = 0; i < HIDDEN_SIZE; i++) begin
            bank_q[i] <= '0;
         end
      end else if (bank_we) begin
         bank_q[s1_q.idx] <= q44_t'(h_new);
      end
   end

   assign out_valid = out_valid_q;
   assign h_out     = h_out_q;
   assign h_idx_out = h_idx_q;
   assign step_done = step_done_q;

endmodule
